// File: rtl/hm01b0_timing_gen.sv
// HM01B0-style camera timing generator: emits vsync/hsync framed test patterns
// (raster count, gradient, checkerboard, frame number) with programmable blanking.
module hm01b0_timing_gen #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int PIX_BITS = 8,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 32
) (
    input  logic                clock,
    input  logic                nreset,
    input  logic                en,
    input  logic [1:0]          mode,
    output logic                vsync,
    output logic                hsync,
    output logic [PIX_BITS-1:0] pixdata,
    output logic [15:0]         frame_count,
    output logic                frame_done,
    output logic [1:0]          state_dbg
);

    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW   = $clog2(BMAX + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [BW-1:0] H_LAST = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] V_LAST = BW'(V_BLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } state_t;

    state_t              state;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [BW-1:0]       blank_cnt;
    logic [PIX_BITS-1:0] raster;
    logic [1:0]          mode_q;
    logic                start_frame;

    // en is a plain level enable, sampled every cycle; there is no back-pressure.
    // A frame starts from IDLE, or back-to-back from the last VBLANK cycle.
    assign start_frame = en && ((state == S_IDLE) ||
                                ((state == S_VBLANK) && (blank_cnt == V_LAST)));
    assign state_dbg   = state;

    function automatic logic [PIX_BITS-1:0] pix_val(
        input logic [1:0]          m,
        input logic [XW-1:0]       px,
        input logic [YW-1:0]       py,
        input logic [PIX_BITS-1:0] rc,
        input logic [15:0]         fc
    );
        logic [PIX_BITS-1:0] v;
        logic                cx;
        logic                cy;
        // Bit 3 of each coordinate selects the 8x8 checker cell; a mask keeps
        // narrow coordinate widths legal (cell bit is then always zero).
        cx = (px & XW'(8)) != '0;
        cy = (py & YW'(8)) != '0;
        case (m)
            2'd0:    v = rc;
            2'd1:    v = PIX_BITS'(px);
            2'd2:    v = {PIX_BITS{cx ^ cy}};
            default: v = PIX_BITS'(fc);
        endcase
        return v;
    endfunction

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            blank_cnt   <= '0;
            raster      <= '0;
            mode_q      <= 2'd0;
            vsync       <= 1'b0;
            hsync       <= 1'b0;
            pixdata     <= '0;
            frame_count <= 16'd0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start_frame) begin
                state   <= S_ACTIVE;
                x       <= '0;
                y       <= '0;
                raster  <= '0;
                mode_q  <= mode;
                vsync   <= 1'b1;
                hsync   <= 1'b1;
                pixdata <= pix_val(mode, '0, '0, '0, frame_count);
            end else begin
                case (state)
                    S_ACTIVE: begin
                        if (x == X_LAST) begin
                            hsync     <= 1'b0;
                            pixdata   <= '0;
                            blank_cnt <= '0;
                            if (y == Y_LAST) begin
                                state       <= S_VBLANK;
                                vsync       <= 1'b0;
                                frame_done  <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                            end else begin
                                state <= S_HBLANK;
                            end
                        end else begin
                            x       <= x + XW'(1);
                            raster  <= raster + PIX_BITS'(1);
                            pixdata <= pix_val(mode_q, x + XW'(1), y,
                                               raster + PIX_BITS'(1), frame_count);
                        end
                    end
                    S_HBLANK: begin
                        if (blank_cnt == H_LAST) begin
                            state   <= S_ACTIVE;
                            x       <= '0;
                            y       <= y + YW'(1);
                            raster  <= raster + PIX_BITS'(1);
                            hsync   <= 1'b1;
                            pixdata <= pix_val(mode_q, '0, y + YW'(1),
                                               raster + PIX_BITS'(1), frame_count);
                        end else begin
                            blank_cnt <= blank_cnt + BW'(1);
                        end
                    end
                    S_VBLANK: begin
                        if (blank_cnt == V_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            blank_cnt <= blank_cnt + BW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hm01b0_timing_gen.sv
// Bench for hm01b0_timing_gen: two configurations (4x3 and 16x16) driven with shared
// random en/mode and compared every cycle against a frame-position arithmetic model.
module tb_hm01b0_timing_gen;

    localparam int NDUT = 2;
    localparam int CW  [NDUT] = '{4, 16};
    localparam int CH  [NDUT] = '{3, 16};
    localparam int CHB [NDUT] = '{2, 4};
    localparam int CVB [NDUT] = '{3, 5};

    logic       clock  = 1'b0;
    logic       nreset = 1'b0;
    logic       en     = 1'b0;
    logic [1:0] mode   = 2'd0;

    logic       vs_w  [NDUT];
    logic       hs_w  [NDUT];
    logic       fd_w  [NDUT];
    logic [7:0] pix_w [NDUT];
    logic [15:0] fc_w [NDUT];
    logic [1:0] st_w  [NDUT];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    hm01b0_timing_gen #(.IMG_W(4), .IMG_H(3), .PIX_BITS(8), .H_BLANK(2), .V_BLANK(3)) dut_a (
        .clock(clock), .nreset(nreset), .en(en), .mode(mode),
        .vsync(vs_w[0]), .hsync(hs_w[0]), .pixdata(pix_w[0]),
        .frame_count(fc_w[0]), .frame_done(fd_w[0]), .state_dbg(st_w[0])
    );

    hm01b0_timing_gen #(.IMG_W(16), .IMG_H(16), .PIX_BITS(8), .H_BLANK(4), .V_BLANK(5)) dut_b (
        .clock(clock), .nreset(nreset), .en(en), .mode(mode),
        .vsync(vs_w[1]), .hsync(hs_w[1]), .pixdata(pix_w[1]),
        .frame_count(fc_w[1]), .frame_done(fd_w[1]), .state_dbg(st_w[1])
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_fd = -1;
    bit period_chk = 1'b0;
    logic [15:0] exp_q[$];

    bit m_idle [NDUT];
    int m_t    [NDUT];
    int m_mode [NDUT];
    int m_fc   [NDUT];

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       fd;
        logic [7:0] pix;
    } exp_t;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    // Position t counts cycles from the first pixel of the frame; lines are
    // IMG_W active + H_BLANK idle, the last line is followed directly by VBLANK.
    function automatic exp_t model_out(int k);
        exp_t e;
        int l, act_end, x, y;
        e = '0;
        l = CW[k] + CHB[k];
        act_end = (CH[k] - 1) * l + CW[k];
        if (!m_idle[k]) begin
            if (m_t[k] < act_end) begin
                y = m_t[k] / l;
                x = m_t[k] % l;
                e.vs = 1'b1;
                if (x < CW[k]) begin
                    e.hs = 1'b1;
                    case (m_mode[k])
                        0:       e.pix = 8'((y * CW[k] + x) % 256);
                        1:       e.pix = 8'(x % 256);
                        2:       e.pix = ((((x / 8) ^ (y / 8)) % 2) == 1) ? 8'hFF : 8'h00;
                        default: e.pix = 8'(m_fc[k] % 256);
                    endcase
                end
            end else begin
                e.fd = (m_t[k] == act_end);
            end
        end
        return e;
    endfunction

    task automatic model_step(input int k, input logic en_v, input logic [1:0] mode_v);
        int l, act_end;
        l = CW[k] + CHB[k];
        act_end = (CH[k] - 1) * l + CW[k];
        if (m_idle[k]) begin
            if (en_v) begin
                m_idle[k] = 1'b0;
                m_t[k]    = 0;
                m_mode[k] = int'(mode_v);
            end
        end else begin
            m_t[k]++;
            if (m_t[k] == act_end) begin
                m_fc[k] = (m_fc[k] + 1) % 65536;
                if (k == 0) exp_q.push_back(16'(m_fc[k]));
            end
            if (m_t[k] == act_end + CVB[k]) begin
                if (en_v) begin
                    m_t[k]    = 0;
                    m_mode[k] = int'(mode_v);
                end else begin
                    m_idle[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_idle[k] = 1'b1;
            m_t[k]    = 0;
            m_mode[k] = 0;
            m_fc[k]   = 0;
        end
        exp_q.delete();
    endtask

    task automatic check_outputs();
        exp_t e;
        logic [15:0] want_fc;
        for (int k = 0; k < NDUT; k++) begin
            e = model_out(k);
            check_eq($sformatf("vsync[%0d]", k), 32'(vs_w[k]), 32'(e.vs));
            check_eq($sformatf("hsync[%0d]", k), 32'(hs_w[k]), 32'(e.hs));
            check_eq($sformatf("frame_done[%0d]", k), 32'(fd_w[k]), 32'(e.fd));
            check_eq($sformatf("pixdata[%0d]", k), 32'(pix_w[k]), 32'(e.pix));
            check_eq($sformatf("frame_count[%0d]", k), 32'(fc_w[k]), 32'(m_fc[k]));
        end
        if (fd_w[0]) begin
            check_eq("fd_queue_depth", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                want_fc = exp_q.pop_front();
                check_eq("fd_frame_count", 32'(fc_w[0]), 32'(want_fc));
            end
            if (period_chk && last_fd >= 0) check_eq("fd_period", 32'(cyc - last_fd), 32'd19);
            last_fd = cyc;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic en_v, input logic [1:0] mode_v);
        @(negedge clock);
        cyc++;
        check_outputs();
        en   = en_v;
        mode = mode_v;
        for (int k = 0; k < NDUT; k++) model_step(k, en_v, mode_v);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("%s_vsync[%0d]", tag, k), 32'(vs_w[k]), 32'd0);
            check_eq($sformatf("%s_hsync[%0d]", tag, k), 32'(hs_w[k]), 32'd0);
            check_eq($sformatf("%s_pix[%0d]", tag, k), 32'(pix_w[k]), 32'd0);
            check_eq($sformatf("%s_fc[%0d]", tag, k), 32'(fc_w[k]), 32'd0);
            check_eq($sformatf("%s_fd[%0d]", tag, k), 32'(fd_w[k]), 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       en_r;
        logic [1:0] mode_r;
        int         waited;
        exp_t       e;

        model_reset();
        repeat (2) @(negedge clock);
        check_all_zero("in_reset");
        nreset = 1'b1;

        // Frame-number pattern from a fresh reset: frames 0,1,2 show 0,1,2.
        for (int i = 0; i < 3 * 19 + 2; i++) cycle(1'b1, 2'd3);

        // Raster count with en held: frame_done every 19 cycles on the 4x3 unit.
        period_chk = 1'b1;
        last_fd = -1;
        for (int i = 0; i < 4 * 19; i++) cycle(1'b1, 2'd0);
        period_chk = 1'b0;

        // en dropped mid-frame: frames finish, then everything idles at zero.
        for (int i = 0; i < 400; i++) cycle(1'b0, 2'd0);

        // Checkerboard over two full 16x16 frames.
        for (int i = 0; i < 2 * 321 + 10; i++) cycle(1'b1, 2'd2);
        for (int i = 0; i < 400; i++) cycle(1'b0, 2'd1);

        // Random en / mode traffic.
        en_r = 1'b1;
        mode_r = 2'd1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en_r = ~en_r;
            if ($urandom_range(0, 24) == 0) mode_r = 2'($urandom_range(0, 3));
            cycle(en_r, mode_r);
        end

        // Asynchronous reset while the 4x3 unit shows pixel (2,1).
        waited = 0;
        while (!(!m_idle[0] && m_t[0] == 1 * 6 + 2) && waited < 200) begin
            cycle(1'b1, 2'd0);
            waited++;
        end
        check_eq("reset_target_reached", 32'(waited < 200), 32'd1);
        @(posedge clock);
        #2;
        e = model_out(0);
        check_eq("pix_2_1", 32'(pix_w[0]), 32'(e.pix));
        nreset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clock);
        cyc++;
        check_outputs();
        nreset = 1'b1;
        en = 1'b1;
        mode = 2'd0;
        for (int k = 0; k < NDUT; k++) model_step(k, 1'b1, 2'd0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 2'd0);

        // frame_count wrap: preload 0xFFFF on the idle 4x3 unit.
        for (int i = 0; i < 400; i++) cycle(1'b0, 2'd0);
        @(negedge clock);
        cyc++;
        check_outputs();
        force dut_a.frame_count = 16'hFFFF;
        #1;
        release dut_a.frame_count;
        m_fc[0] = 16'hFFFF;
        for (int i = 0; i < 25; i++) cycle(1'b1, 2'd3);
        for (int i = 0; i < 400; i++) cycle(1'b0, 2'd0);

        check_eq("fd_queue_left", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hm01b0_timing_gen.md
HM01B0_TIMING_GEN -- requirements
Module: hm01b0_timing_gen

Interface
REQ-001 Parameter IMG_W, 320, active pixels per line; SHALL be >= 2.
REQ-002 Parameter IMG_H, 240, active lines per frame; SHALL be >= 1.
REQ-003 Parameter PIX_BITS, 8, pixdata width; SHALL be 1..16.
REQ-004 Parameter H_BLANK, 16, idle cycles between lines within a frame; SHALL be >= 1.
REQ-005 Parameter V_BLANK, 32, idle cycles after the last line of a frame; SHALL be >= 1.
REQ-006 clock  input  1  single clock; all state SHALL change on its rising edge.
REQ-007 nreset  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  frame-stream enable.
REQ-009 mode  input  2  pattern select: 0 raster count, 1 horizontal gradient, 2 checkerboard, 3 frame number.
REQ-010 vsync  output  1  frame valid; high from the first pixel of line 0 through the last pixel of line IMG_H-1.
REQ-011 hsync  output  1  line valid; high only on active pixel cycles.
REQ-012 pixdata  output  PIX_BITS  pixel value; SHALL be 0 whenever hsync is low.
REQ-013 frame_count  output  16  completed frames; wraps 0xFFFF->0x0000.
REQ-014 frame_done  output  1  one-cycle pulse on the first V_BLANK cycle of each frame.

Function
REQ-015 The block SHALL implement the states IDLE, ACTIVE, HBLANK and VBLANK; all outputs SHALL be registered.
REQ-016 IDLE: when en=1 is sampled, the next cycle SHALL be ACTIVE at x=0, y=0, showing vsync=1, hsync=1 and pixel(0,0) (latency 1 cycle).
REQ-017 ACTIVE: IMG_W consecutive cycles, x=0..IMG_W-1; after x=IMG_W-1 the block SHALL go to HBLANK if y<IMG_H-1, otherwise to VBLANK.
REQ-018 HBLANK: exactly H_BLANK cycles with hsync=0 and vsync=1; then ACTIVE with y+1 and x=0.
REQ-019 VBLANK: exactly V_BLANK cycles with vsync=0 and hsync=0; then ACTIVE (new frame) if en=1 on the last VBLANK cycle, otherwise IDLE.
REQ-020 Frame period SHALL be IMG_H*IMG_W + (IMG_H-1)*H_BLANK + V_BLANK cycles (80656 at defaults).
REQ-021 en deasserted mid-frame SHALL NOT truncate the frame; the current frame and its VBLANK complete first.
REQ-022 mode SHALL be latched on the cycle that enters ACTIVE at x=0, y=0; changes within a frame SHALL NOT take effect until the next frame.
REQ-023 Mode 0: pixdata = (y*IMG_W + x) mod 2^PIX_BITS, from a per-frame counter that restarts at 0.
REQ-024 Mode 1: pixdata = x mod 2^PIX_BITS.
REQ-025 Mode 2: pixdata = all ones if (x/8 XOR y/8) is odd, otherwise 0.
REQ-026 Mode 3: pixdata = frame_count[PIX_BITS-1:0], constant over the frame.
REQ-027 frame_count SHALL increment on the same edge that raises frame_done, so the new value is visible in the cycle where frame_done=1.
REQ-028 frame_done and the start of a new frame SHALL never coincide, because V_BLANK >= 1.

Reset
REQ-029 nreset low SHALL immediately force vsync=0, hsync=0, pixdata=0, frame_count=0, frame_done=0, state IDLE, x=y=0, latched mode=0.
REQ-030 On nreset release the block SHALL stay in IDLE until en=1 is sampled; reset mid-frame SHALL abandon the frame without asserting frame_done.

Verification
REQ-031 Parameters IMG_W=4, IMG_H=3, H_BLANK=2, V_BLANK=3, mode=0, en held high -> frame period 19 cycles; hsync pattern 1111 00 1111 00 1111 000; pixdata 0..11; frame_done pulses every 19 cycles.
REQ-032 Same parameters, en dropped on the 5th cycle of frame 1 -> frame 1 completes all 12 pixels and the VBLANK, frame_count=1, then IDLE with all outputs 0.
REQ-033 mode=3 held for 3 frames, PIX_BITS=8 -> every active pixel equals 0, 1, 2 in frames 0, 1, 2 respectively.
REQ-034 IMG_W=16, IMG_H=16, mode=2 -> pixel(0,0)=0x00, pixel(8,0)=0xFF, pixel(8,8)=0x00, pixel(0,8)=0xFF.
REQ-035 nreset pulsed low on pixel (2,1) -> outputs are 0 within the same cycle, without waiting for a clock edge; after release with en=1, pixel(0,0) follows 1 cycle after en is sampled and frame_count=0.
REQ-036 frame_count preloaded by running 65536 frames (or forced to 0xFFFF) -> the next frame_done shows frame_count=0x0000.
